// File: rtl/add_wide_seq.sv
// Sequences a WORDS x 16-bit add through an external 16-bit adder, one slice per cycle, LSB first.
// Optional subtraction support is built when ADD_WIDE_SUB_EN is defined.
module add_wide_seq #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   op_a,
   input  logic [16*WORDS-1:0]   op_b,
   input  logic                  c_in,
`ifdef ADD_WIDE_SUB_EN
   input  logic                  sub,
`endif
   output logic [15:0]           add_a,
   output logic [15:0]           add_b,
   output logic                  add_cin,
   input  logic [15:0]           add_sum,
   input  logic                  add_cout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   result,
   output logic                  c_out,
   output logic                  ovf
);

   // state | meaning
   // IDLE  | waiting for an operand pair, in_ready high
   // RUN   | feeding slice idx to the external adder
   // DONE  | result presented, waiting for out_ready

   localparam int W  = 16 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, next_state;
   logic [W-1:0]    a_reg, b_reg;
   logic            cin_reg, carry_reg;
   logic [IW-1:0]   idx;
   logic            sub_sel;
   logic            accept, last;

`ifdef ADD_WIDE_SUB_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   assign accept = (state == IDLE) && in_valid;
   assign last   = (idx == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      add_a      = '0;
      add_b      = '0;
      add_cin    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = RUN;
         end
         RUN: begin
            add_a   = a_reg[16*idx +: 16];
            add_b   = b_reg[16*idx +: 16];
            add_cin = (idx == '0) ? cin_reg : carry_reg;
            if (last) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Subtraction stores ~op_b with a forced carry-in, so the overflow rule below sees the inverted b MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         cin_reg   <= 1'b0;
         carry_reg <= 1'b0;
         idx       <= '0;
         result    <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
      end else if (accept) begin
         a_reg   <= op_a;
         b_reg   <= sub_sel ? ~op_b : op_b;
         cin_reg <= sub_sel ? 1'b1 : c_in;
         idx     <= '0;
      end else if (state == RUN) begin
         result[16*idx +: 16] <= add_sum;
         carry_reg            <= add_cout;
         if (last) begin
            c_out <= add_cout;
            ovf   <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[15] != a_reg[W-1]);
            idx   <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_add_wide_seq.sv
// Bench for add_wide_seq (WORDS=4) with a behavioural 16-bit adder and a plain-arithmetic reference model.
// Exercises subtraction vectors too when ADD_WIDE_SUB_EN is defined.
module tb_add_wide_seq;
   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  op_a, op_b;
   logic          c_in, sub_in;
   logic [15:0]   add_a, add_b, add_sum;
   logic          add_cin, add_cout;
   logic          out_valid, out_ready;
   logic [W-1:0]  result;
   logic          c_out, ovf;
   logic [16:0]   adder_full;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
   assign add_sum    = adder_full[15:0];
   assign add_cout   = adder_full[16];

   add_wide_seq #(.WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .c_in(c_in),
`ifdef ADD_WIDE_SUB_EN
      .sub(sub_in),
`endif
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .c_out(c_out), .ovf(ovf)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sb;
      logic [W-1:0] exp_r;
      logic         exp_co;
      logic         exp_ov;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                 input logic sb, output logic [W-1:0] r, output logic co,
                                 output logic ov);
      logic [W:0] t;
      if (sb) begin
         r  = a - b;
         co = (a >= b);
         ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end else begin
         t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
         r  = t[W-1:0];
         co = t[W];
         ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
   endfunction

   // Called right after the accepting edge; counts edges until out_valid.
   task automatic wait_done();
      int n = 0;
      check("accept_ready_low", {63'b0, in_ready}, 64'd0);
      while (!out_valid && n < WORDS + 4) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 64'(n), 64'(WORDS));
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, input int hold, output logic [W-1:0] r,
                         output logic co, output logic ov);
      op_a = a; op_b = b; c_in = ci; sub_in = sb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      c_in = ~ci;
      sub_in = ~sb;
      wait_done();
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         check("hold_out_valid", {63'b0, out_valid}, 64'd1);
         check("hold_in_ready", {63'b0, in_ready}, 64'd0);
      end
      r = result; co = c_out; ov = ovf;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("back_to_idle", {63'b0, in_ready}, 64'd1);
   endtask

   initial begin
      logic [W-1:0] r, ea, eb, er;
      logic         co, ov, eco, eov, rsb;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; c_in = 1'b0; sub_in = 1'b0;
      #12;
      check("rst_in_ready", {63'b0, in_ready}, 64'd1);
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_c_out", {63'b0, c_out}, 64'd0);
      check("rst_add_a", {48'b0, add_a}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op_a = 64'hDEAD_BEEF_1234_5678;
      #1;
      check("idle_add_a_zero", {48'b0, add_a}, 64'd0);

      vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0});
      vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0});
      vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1});
      vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1});
      vecs.push_back('{64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0});
      vecs.push_back('{64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 64'h0011_0022_0033_0045, 1'b0, 1'b0});
`ifdef ADD_WIDE_SUB_EN
      vecs.push_back('{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
      vecs.push_back('{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
`endif

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, i % 3, r, co, ov);
         check($sformatf("vec%0d_result", i), r, vecs[i].exp_r);
         check($sformatf("vec%0d_c_out", i), {63'b0, co}, {63'b0, vecs[i].exp_co});
         check($sformatf("vec%0d_ovf", i), {63'b0, ov}, {63'b0, vecs[i].exp_ov});
      end

      // Backpressure: DONE held 3 cycles with new operands offered, then they are accepted.
      op_a = 64'h0000_0000_0000_1234; op_b = 64'h1; c_in = 1'b0; sub_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      op_a = 64'h0000_0001_0000_0000; op_b = 64'h0000_0000_FFFF_FFFF; c_in = 1'b1;
      wait_done();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("bp_result_held", result, 64'h1235);
         check("bp_in_ready", {63'b0, in_ready}, 64'd0);
         check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_idle_ready", {63'b0, in_ready}, 64'd1);
      check("bp_idle_valid", {63'b0, out_valid}, 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done();
      check("bp_second_result", result, 64'h0000_0002_0000_0000);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset after two RUN cycles aborts the operation.
      op_a = 64'h0000_5555_0000_0001; op_b = 64'h0000_0000_0000_0002; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_run_add_a", {48'b0, add_a}, 64'h5555);
      #2 rst_n = 1'b0;
      #1;
      check("abort_in_ready", {63'b0, in_ready}, 64'd1);
      check("abort_out_valid", {63'b0, out_valid}, 64'd0);
      check("abort_result", result, 64'd0);
      check("abort_flags", {62'b0, c_out, ovf}, 64'd0);
      check("abort_adder", {31'b0, add_a, add_b, add_cin}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(64'd3, 64'd4, 1'b0, 1'b0, 0, r, co, ov);
      check("post_reset_3p4", r, 64'd7);

      // Randomized operations against the reference model.
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(3))
            0: ea = 64'hFFFF_FFFF_FFFF_FFFF;
            1: ea = 64'h7FFF_FFFF_FFFF_FFFF;
            default: ea = {$urandom, $urandom};
         endcase
         eb = ($urandom_range(3) == 0) ? {32'b0, $urandom} : {$urandom, $urandom};
`ifdef ADD_WIDE_SUB_EN
         rsb = 1'($urandom_range(1));
`else
         rsb = 1'b0;
`endif
         co = 1'($urandom_range(1));
         model(ea, eb, co, rsb, er, eco, eov);
         run_op(ea, eb, co, rsb, $urandom_range(2), r, co, ov);
         check($sformatf("rnd%0d_result", t), r, er);
         check($sformatf("rnd%0d_flags", t), {62'b0, co, ov}, {62'b0, eco, eov});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
